// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns an EX/MEM load/store into one req/ack bus beat,
// extends load data for MEM/WB, flags misalignment and bus timeouts, and stalls upstream meanwhile.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] dm_data_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, dm_q, dm_d;
  logic [3:0]        be_q, be_d;

  logic        access, in_b, in_h, in_w, misal;
  logic        lb, lh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext;

  // Size decode: anything that is not B/BU/H/HU behaves as a word access.
  assign access = mem_read_i | mem_write_i;
  assign in_b   = (funct3_i == 3'b000) || (funct3_i == 3'b100);
  assign in_h   = (funct3_i == 3'b001) || (funct3_i == 3'b101);
  assign in_w   = !in_b && !in_h;
  assign misal  = (in_h && addr_i[0]) || (in_w && (addr_i[1:0] != 2'b00));

  assign lb    = (f3_q == 3'b000) || (f3_q == 3'b100);
  assign lh    = (f3_q == 3'b001) || (f3_q == 3'b101);
  assign rbyte = bus_rdata_i[{off_q, 3'b000} +: 8];
  assign rhalf = bus_rdata_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ext = bus_rdata_i;
    if (lb)      ext = f3_q[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
    else if (lh) ext = f3_q[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
  end

  // Stall and misalign are combinational so the pipeline reacts in the access cycle itself;
  // both are forced low while reset is held.
  assign misalign_o = rst_i && (state_q == IDLE) && access && misal;
  assign stall_o    = rst_i && ((state_q == REQ) ||
                                ((state_q == IDLE) && access && !misal));
  assign dm_data_o  = misalign_o ? 32'h0 : dm_q;

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign bus_err_o   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    dm_d    = dm_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && misal) begin
          dm_d = 32'h0;
        end else if (access) begin
          f3_d   = funct3_i;
          off_d  = addr_i[1:0];
          req_d  = 1'b1;
          we_d   = mem_write_i;
          addr_d = {addr_i[31:2], 2'b00};
          cnt_d  = '0;
          if (!mem_write_i) begin
            be_d    = 4'b1111;
            wdata_d = 32'h0;
          end else if (in_b) begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
          end else if (in_h) begin
            be_d    = 4'b0011 << addr_i[1:0];
            wdata_d = {2{wdata_i[15:0]}};
          end else begin
            be_d    = 4'b1111;
            wdata_d = wdata_i;
          end
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack arriving in the timeout cycle still completes the access.
        if (bus_ack_i) begin
          dm_d    = we_q ? 32'h0 : ext;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          dm_d    = 32'h0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      dm_q    <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      dm_q    <= dm_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed bus lanes, load extension, misalign,
// timeout and mid-access reset.
module tb_mem_access_unit;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b0;
  logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
  logic        stall_o, misalign_o, bus_err_o, bus_req_o, bus_we_o;
  logic [31:0] dm_data_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_rdata_i = 32'h0;
  logic        bus_ack_i = 1'b0;

  int total = 0, bad = 0;
  int stalls;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;

  mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .dm_data_o(dm_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Presents one access and plays the bus: ack comes in REQ cycle wait_n (0-based), never if
  // wait_n<0. Returns with the bench sitting in the first non-stalled cycle.
  task automatic run_acc(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int wait_n, input logic [31:0] rdat);
    int k;
    @(negedge clk_i);
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
    #1;
    stalls = 0; k = 0;
    while (stall_o && stalls < 40) begin
      stalls++;
      @(negedge clk_i);
      mem_read_i = 1'b0; mem_write_i = 1'b0;
      bus_ack_i = (wait_n >= 0) && (k == wait_n);
      bus_rdata_i = rdat;
      k++;
      #1;
      if (bus_req_o) begin
        s_we = bus_we_o; s_addr = bus_addr_o; s_be = bus_be_o; s_wdata = bus_wdata_o;
      end
    end
    bus_ack_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    #1;
  endtask

  initial begin
    #12 rst_i = 1'b1;
    #1;
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_req", {31'b0, bus_req_o}, 32'h0);
    chk("rst_dm", dm_data_o, 32'h0);
    chk("rst_flags", {30'b0, misalign_o, bus_err_o}, 32'h0);
    chk("rst_be", {28'b0, bus_be_o}, 32'h0);

    run_acc(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    chk("lw_stalls", stalls, 2);
    chk("lw_dm", dm_data_o, 32'hDEADBEEF);
    chk("lw_req_done", {31'b0, bus_req_o}, 32'h0);
    chk("lw_err", {31'b0, bus_err_o}, 32'h0);
    chk("lw_addr", s_addr, 32'h100);
    chk("lw_be", {28'b0, s_be}, 32'hF);
    chk("lw_we", {31'b0, s_we}, 32'h0);

    run_acc(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_0000);
    chk("lb_dm", dm_data_o, 32'hFFFFFF80);
    run_acc(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_0000);
    chk("lbu_stalls", stalls, 3);
    chk("lbu_dm", dm_data_o, 32'h00000080);
    run_acc(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF_0000);
    chk("lh_dm", dm_data_o, 32'hFFFF80FF);
    run_acc(1, 0, 3'b101, 32'h102, 32'h0, 0, 32'h80FF_0000);
    chk("lhu_dm", dm_data_o, 32'h000080FF);
    run_acc(1, 0, 3'b000, 32'h101, 32'h0, 0, 32'h1234_C5AA);
    chk("lb_off1_dm", dm_data_o, 32'hFFFFFFC5);

    // Misaligned word load: flag, no stall, no bus, data forced to zero.
    run_acc(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    chk("mis_stalls", stalls, 0);
    chk("mis_flag", {31'b0, misalign_o}, 32'h1);
    chk("mis_dm", dm_data_o, 32'h0);
    idle_cycle();
    chk("mis_req", {31'b0, bus_req_o}, 32'h0);
    chk("mis_flag_gone", {31'b0, misalign_o}, 32'h0);
    run_acc(0, 1, 3'b001, 32'h201, 32'h1234, 0, 32'h0);
    chk("mis_sh_flag", {31'b0, misalign_o}, 32'h1);
    idle_cycle();

    run_acc(0, 1, 3'b000, 32'h201, 32'h000000AB, 0, 32'h0);
    chk("sb_be", {28'b0, s_be}, 32'h2);
    chk("sb_wdata", s_wdata, 32'hABABABAB);
    chk("sb_we", {31'b0, s_we}, 32'h1);
    chk("sb_addr", s_addr, 32'h200);
    chk("sb_dm", dm_data_o, 32'h0);
    run_acc(0, 1, 3'b001, 32'h202, 32'h5555_1234, 2, 32'h0);
    chk("sh_stalls", stalls, 4);
    chk("sh_be", {28'b0, s_be}, 32'hC);
    chk("sh_wdata", s_wdata, 32'h12341234);
    run_acc(1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h11111111);
    chk("rw_we", {31'b0, s_we}, 32'h1);
    chk("rw_wdata", s_wdata, 32'hCAFEF00D);
    chk("rw_dm", dm_data_o, 32'h0);

    // Stray ack in IDLE must not disturb dm_data_o.
    run_acc(1, 0, 3'b010, 32'h104, 32'h0, 0, 32'h0BADF00D);
    @(negedge clk_i); bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    @(negedge clk_i); bus_ack_i = 1'b0; #1;
    chk("stray_ack_dm", dm_data_o, 32'h0BADF00D);

    run_acc(1, 0, 3'b010, 32'h400, 32'h0, -1, 32'h0);
    chk("to_stalls", stalls, 17);
    chk("to_err", {31'b0, bus_err_o}, 32'h1);
    chk("to_dm", dm_data_o, 32'h0);
    chk("to_req", {31'b0, bus_req_o}, 32'h0);
    idle_cycle();
    chk("to_err_gone", {31'b0, bus_err_o}, 32'h0);

    run_acc(1, 0, 3'b010, 32'h404, 32'h0, 15, 32'h600DCAFE);
    chk("late_ack_stalls", stalls, 17);
    chk("late_ack_err", {31'b0, bus_err_o}, 32'h0);
    chk("late_ack_dm", dm_data_o, 32'h600DCAFE);

    // Reset while in REQ drops the request and stall at once.
    @(negedge clk_i);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500;
    @(negedge clk_i);
    mem_read_i = 1'b0; #1;
    chk("pre_rst_req", {31'b0, bus_req_o}, 32'h1);
    rst_i = 1'b0; #1;
    chk("mid_rst_req", {31'b0, bus_req_o}, 32'h0);
    chk("mid_rst_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk_i); rst_i = 1'b1;
    idle_cycle();
    chk("post_rst_req", {31'b0, bus_req_o}, 32'h0);
    run_acc(1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h13572468);
    chk("post_rst_stalls", stalls, 2);
    chk("post_rst_dm", dm_data_o, 32'h13572468);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
